// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer: PC, IR and fetch/execute phase
// Drives the ROM address and presents opcode/operand/phase to the decoder.
module fetch_sequencer #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 8,
  parameter int OPC_W   = 4,
  parameter int ROM_LAT = 0
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ENABLE,
  input  logic                     LOAD_PC,
  input  logic [ADDR_W-1:0]        LOAD_ADDR,
  input  logic                     HALT_REQ,
  input  logic                     RESUME,
  input  logic [INSTR_W-1:0]       ROM_DATA,
  output logic [ADDR_W-1:0]        ROM_ADDR,
  output logic [ADDR_W-1:0]        PC,
  output logic [OPC_W-1:0]         OPCODE,
  output logic [INSTR_W-OPC_W-1:0] OPERAND,
  output logic                     PHASE,
  output logic                     VALID,
  output logic                     HALTED,
  output logic                     WRAP
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir;
  logic [INSTR_W-1:0]  w_ir_nxt;
  logic                r_wrap;
  logic                w_wrap_nxt;
  logic [ADDR_W:0]     w_pc_inc;
  logic                w_load_ir;

  // The carry out of the increment is the wrap event.
  assign w_pc_inc  = {1'b0, r_pc} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_load_ir = (r_state == ST_WAIT) || ((r_state == ST_FETCH) && (ROM_LAT == 0));

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_wrap  <= 1'b0;
    end else if (ENABLE) begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_wrap_nxt  = r_wrap;
    if (w_load_ir) begin
      w_ir_nxt    = ROM_DATA;
      w_pc_nxt    = w_pc_inc[ADDR_W-1:0];
      w_state_nxt = ST_EXEC;
      if (w_pc_inc[ADDR_W]) begin
        w_wrap_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        ST_FETCH: w_state_nxt = ST_WAIT;
        ST_EXEC: begin
          if (HALT_REQ) begin
            w_state_nxt = ST_HALT;
          end else if (LOAD_PC) begin
            w_pc_nxt    = LOAD_ADDR;
            w_wrap_nxt  = 1'b0;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_FETCH;
          end
        end
        ST_HALT: begin
          if (RESUME) begin
            w_state_nxt = ST_FETCH;
          end
        end
        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

  assign ROM_ADDR = r_pc;
  assign PC       = r_pc;
  assign OPCODE   = r_ir[INSTR_W-1 -: OPC_W];
  assign OPERAND  = r_ir[INSTR_W-OPC_W-1:0];
  assign PHASE    = (r_state == ST_EXEC);
  assign VALID    = (r_state == ST_EXEC);
  assign HALTED   = (r_state == ST_HALT);
  assign WRAP     = r_wrap;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - bench for fetch_sequencer with ROM_LAT=0 (dut0) and ROM_LAT=1 (dut1)
// A per-instance instruction-level model is compared every cycle; directed steps pin literal values.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        en      [2];
  logic        ld      [2];
  logic [11:0] ld_addr [2];
  logic        hr      [2];
  logic        rs      [2];
  logic [7:0]  rd      [2];
  logic [11:0] rom_addr_o [2];
  logic [11:0] pc_o    [2];
  logic [3:0]  opc_o   [2];
  logic [3:0]  opr_o   [2];
  logic        phase_o [2];
  logic        valid_o [2];
  logic        halted_o[2];
  logic        wrap_o  [2];

  logic [7:0]  rom [2][4096];

  int n_chk = 0;
  int n_err = 0;

  fetch_sequencer #(.ADDR_W(12), .INSTR_W(8), .OPC_W(4), .ROM_LAT(0)) u_dut0 (
    .CLK(clk), .RST(rst[0]), .ENABLE(en[0]), .LOAD_PC(ld[0]), .LOAD_ADDR(ld_addr[0]),
    .HALT_REQ(hr[0]), .RESUME(rs[0]), .ROM_DATA(rd[0]), .ROM_ADDR(rom_addr_o[0]),
    .PC(pc_o[0]), .OPCODE(opc_o[0]), .OPERAND(opr_o[0]), .PHASE(phase_o[0]),
    .VALID(valid_o[0]), .HALTED(halted_o[0]), .WRAP(wrap_o[0])
  );

  fetch_sequencer #(.ADDR_W(12), .INSTR_W(8), .OPC_W(4), .ROM_LAT(1)) u_dut1 (
    .CLK(clk), .RST(rst[1]), .ENABLE(en[1]), .LOAD_PC(ld[1]), .LOAD_ADDR(ld_addr[1]),
    .HALT_REQ(hr[1]), .RESUME(rs[1]), .ROM_DATA(rd[1]), .ROM_ADDR(rom_addr_o[1]),
    .PC(pc_o[1]), .OPCODE(opc_o[1]), .OPERAND(opr_o[1]), .PHASE(phase_o[1]),
    .VALID(valid_o[1]), .HALTED(halted_o[1]), .WRAP(wrap_o[1])
  );

  // Combinational ROM for dut0, registered ROM for dut1.
  assign rd[0] = rom[0][rom_addr_o[0]];
  always @(posedge clk) rd[1] <= rom[1][rom_addr_o[1]];

  // Model: stage counts enabled cycles into the current instruction; stage==lat+1 is execute.
  int  m_pc    [2];
  int  m_ir    [2];
  int  m_stage [2];
  bit  m_halt  [2];
  bit  m_wrap  [2];
  bit  m_live  [2] = '{1'b0, 1'b0};

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k] === 1'b0) begin
        m_pc[k] = 0; m_ir[k] = 0; m_stage[k] = 0;
        m_halt[k] = 1'b0; m_wrap[k] = 1'b0; m_live[k] = 1'b1;
      end else if (m_live[k] && en[k]) begin
        if (m_halt[k]) begin
          if (rs[k]) begin m_halt[k] = 1'b0; m_stage[k] = 0; end
        end else if (m_stage[k] == k + 1) begin
          if (hr[k]) m_halt[k] = 1'b1;
          else begin
            if (ld[k]) begin m_pc[k] = int'(ld_addr[k]); m_wrap[k] = 1'b0; end
            m_stage[k] = 0;
          end
        end else if (m_stage[k] == k) begin
          m_ir[k] = int'(rom[k][m_pc[k]]);
          if (m_pc[k] == 4095) m_wrap[k] = 1'b1;
          m_pc[k] = (m_pc[k] + 1) % 4096;
          m_stage[k] = k + 1;
        end else begin
          m_stage[k] = m_stage[k] + 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_live[k]) begin
        bit ex;
        ex = !m_halt[k] && (m_stage[k] == k + 1);
        check($sformatf("dut%0d pc", k),       32'(pc_o[k]),       32'(m_pc[k]));
        check($sformatf("dut%0d rom_addr", k), 32'(rom_addr_o[k]), 32'(m_pc[k]));
        check($sformatf("dut%0d opcode", k),   32'(opc_o[k]),      32'(m_ir[k] >> 4));
        check($sformatf("dut%0d operand", k),  32'(opr_o[k]),      32'(m_ir[k] & 15));
        check($sformatf("dut%0d phase", k),    32'(phase_o[k]),    32'(ex));
        check($sformatf("dut%0d valid", k),    32'(valid_o[k]),    32'(ex));
        check($sformatf("dut%0d halted", k),   32'(halted_o[k]),   32'(m_halt[k]));
        check($sformatf("dut%0d wrap", k),     32'(wrap_o[k]),     32'(m_wrap[k]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom[0][i] = 8'(i * 7 + 3);
      rom[1][i] = 8'(i * 13 + 5);
    end
    rom[0][0] = 8'h35; rom[0][1] = 8'hA7; rom[0][2] = 8'h1F;
    rom[1][0] = 8'hC2;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0; en[k] = 1'b0; ld[k] = 1'b0; ld_addr[k] = '0; hr[k] = 1'b0; rs[k] = 1'b0;
    end
    step(); step();
    for (int k = 0; k < 2; k++) begin
      check("reset pc", 32'(pc_o[k]), 32'h0);
      check("reset phase", 32'(phase_o[k]), 32'h0);
      check("reset valid", 32'(valid_o[k]), 32'h0);
      check("reset halted", 32'(halted_o[k]), 32'h0);
      check("reset wrap", 32'(wrap_o[k]), 32'h0);
      check("reset opcode", 32'(opc_o[k]), 32'h0);
    end

    // Sequential fetch, combinational ROM.
    rst[0] = 1'b1; en[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("seq phase toggle", 32'(phase_o[0]), 32'(i % 2));
      if (i == 1) begin
        check("seq first opcode", 32'(opc_o[0]), 32'h3);
        check("seq first operand", 32'(opr_o[0]), 32'h5);
        check("seq first pc", 32'(pc_o[0]), 32'h1);
      end
    end
    check("seq pc after 6", 32'(pc_o[0]), 32'h3);
    check("seq last opcode", 32'(opc_o[0]), 32'h1);

    // Jump from EXEC at PC=5; LOAD_PC held into FETCH must not reload.
    step(); step(); step();
    check("jump pre pc", 32'(pc_o[0]), 32'h5);
    check("jump pre phase", 32'(phase_o[0]), 32'h1);
    ld[0] = 1'b1; ld_addr[0] = 12'h0F0;
    step();
    check("jump pc", 32'(pc_o[0]), 32'h0F0);
    check("jump phase", 32'(phase_o[0]), 32'h0);
    ld_addr[0] = 12'h0AA;
    step();
    check("jump held in fetch pc", 32'(pc_o[0]), 32'h0F1);
    ld[0] = 1'b0;
    step(); step();
    check("exec pc before halt", 32'(pc_o[0]), 32'h0F2);

    // Halt beats load; load ignored while halted; resume refetches at same PC.
    hr[0] = 1'b1; ld[0] = 1'b1; ld_addr[0] = 12'h100;
    step();
    check("halt halted", 32'(halted_o[0]), 32'h1);
    check("halt pc", 32'(pc_o[0]), 32'h0F2);
    hr[0] = 1'b0;
    step(); step();
    check("halt load ignored pc", 32'(pc_o[0]), 32'h0F2);
    check("halt still halted", 32'(halted_o[0]), 32'h1);
    ld[0] = 1'b0; rs[0] = 1'b1;
    step();
    check("resume halted", 32'(halted_o[0]), 32'h0);
    check("resume phase", 32'(phase_o[0]), 32'h0);
    rs[0] = 1'b0;
    step();
    check("resume fetch pc", 32'(pc_o[0]), 32'h0F3);

    // Wrap, ENABLE gating, wrap cleared by honoured load.
    ld[0] = 1'b1; ld_addr[0] = 12'hFFF;
    step();
    check("wrap load pc", 32'(pc_o[0]), 32'hFFF);
    ld[0] = 1'b0;
    step();
    check("wrap pc", 32'(pc_o[0]), 32'h000);
    check("wrap flag", 32'(wrap_o[0]), 32'h1);
    en[0] = 1'b0; ld[0] = 1'b1; ld_addr[0] = 12'h123; hr[0] = 1'b1; rs[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("gated pc", 32'(pc_o[0]), 32'h000);
      check("gated wrap", 32'(wrap_o[0]), 32'h1);
      check("gated phase", 32'(phase_o[0]), 32'h1);
      check("gated ir", 32'({opc_o[0], opr_o[0]}), 32'hFC);
    end
    en[0] = 1'b1; hr[0] = 1'b0; rs[0] = 1'b0; ld_addr[0] = 12'h010;
    step();
    check("wrap clear pc", 32'(pc_o[0]), 32'h010);
    check("wrap clear flag", 32'(wrap_o[0]), 32'h0);
    ld[0] = 1'b0; en[0] = 1'b0;

    // Registered ROM: FETCH, WAIT, EXEC.
    rst[1] = 1'b1; en[1] = 1'b1;
    step();
    check("lat1 wait phase", 32'(phase_o[1]), 32'h0);
    check("lat1 wait pc", 32'(pc_o[1]), 32'h0);
    step();
    check("lat1 exec valid", 32'(valid_o[1]), 32'h1);
    check("lat1 exec opcode", 32'(opc_o[1]), 32'hC);
    check("lat1 exec operand", 32'(opr_o[1]), 32'h2);
    check("lat1 exec pc", 32'(pc_o[1]), 32'h1);

    // Reset mid-WAIT wins over ENABLE and RESUME.
    ld[1] = 1'b1; ld_addr[1] = 12'h07A;
    step();
    ld[1] = 1'b0;
    step();
    check("lat1 wait pc 07a", 32'(pc_o[1]), 32'h07A);
    check("lat1 wait valid", 32'(valid_o[1]), 32'h0);
    rst[1] = 1'b0; rs[1] = 1'b1;
    step();
    check("midreset pc", 32'(pc_o[1]), 32'h0);
    check("midreset valid", 32'(valid_o[1]), 32'h0);
    check("midreset wrap", 32'(wrap_o[1]), 32'h0);
    check("midreset halted", 32'(halted_o[1]), 32'h0);
    rst[1] = 1'b1; rs[1] = 1'b0;
    step(); step(); step();
    check("post reset refetch pc", 32'(pc_o[1]), 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Parametrised instruction-fetch sequencer for the uP core. It combines the program counter, the instruction register and the fetch/execute phase flip-flop into one block. It adds jump loading, a halt/resume mode, optional 1-cycle ROM read latency and PC wrap detection. It drives the ROM address and feeds opcode, operand and phase to the decoder.

Parameters:
- ADDR_W, 12, program counter and ROM address width.
- INSTR_W, 8, instruction (ROM word) width.
- OPC_W, 4, opcode field width taken from the IR MSBs. Must satisfy 1 <= OPC_W < INSTR_W.
- ROM_LAT, 0, ROM read latency in cycles. Only 0 (combinational ROM) or 1 (registered ROM) is legal.

Ports:
- CLK  in  1  clock, all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset, sampled on the CLK rising edge.
- ENABLE  in  1  advance enable. When 0, all state holds.
- LOAD_PC  in  1  jump request, honoured only in EXEC.
- LOAD_ADDR  in  ADDR_W  jump target.
- HALT_REQ  in  1  enter HALT from EXEC.
- RESUME  in  1  leave HALT.
- ROM_DATA  in  INSTR_W  ROM read data.
- ROM_ADDR  out  ADDR_W  equals PC at all times.
- PC  out  ADDR_W  program counter.
- OPCODE  out  OPC_W  IR[INSTR_W-1 : INSTR_W-OPC_W].
- OPERAND  out  INSTR_W-OPC_W  IR remaining LSBs.
- PHASE  out  1  1 in EXEC, 0 otherwise (decoder phase bit).
- VALID  out  1  IR holds a fresh instruction (state EXEC).
- HALTED  out  1  state HALT.
- WRAP  out  1  sticky PC wrap flag.

Behaviour:
- Reset: RST=0 at a rising edge sets PC=0, IR=0, state=FETCH, WRAP=0. Outputs after reset: PHASE=0, VALID=0, HALTED=0. Reset has priority over ENABLE and every other input, in any state and mid-sequence.
- ENABLE=0: PC, IR, state and WRAP hold; all other inputs are ignored.
- States are FETCH, WAIT, EXEC and HALT. WAIT is reachable only when ROM_LAT=1.
- FETCH, ROM_LAT=0: IR<=ROM_DATA, PC<=PC+1, next state EXEC. Result: 2 enabled cycles per instruction.
- FETCH, ROM_LAT=1: next state WAIT; PC and IR hold.
- WAIT: IR<=ROM_DATA, which is the data for the address held during FETCH. PC<=PC+1, next state EXEC. Result: 3 enabled cycles per instruction.
- EXEC: priority is HALT_REQ > LOAD_PC > default.
  - HALT_REQ=1: next state HALT; PC unchanged.
  - LOAD_PC=1: PC<=LOAD_ADDR, WRAP<=0, next state FETCH.
  - Otherwise: next state FETCH; PC holds (it already points at the next instruction).
- HALT: PC and IR hold; LOAD_PC and HALT_REQ are ignored. RESUME=1 gives next state FETCH.
- LOAD_PC in FETCH/WAIT is ignored; PC is not modified.
- Increment wraps modulo 2^ADDR_W. An increment from all-ones to 0 sets WRAP=1. WRAP stays set until reset or an honoured LOAD_PC.
- PHASE, VALID and HALTED are decoded from the registered state only (no combinational path from inputs). OPCODE and OPERAND are decoded from IR only.
- No X on any output after the first reset edge.

Test Plan:
- Reset and sequential fetch, ROM_LAT=0: RST=0 for 2 cycles, then ENABLE=1 with ROM[0..2]=8'h35,8'hA7,8'h1F.
  - Required: PHASE toggles 0,1,0,1...
  - In the EXEC cycle after fetching address 0: OPCODE=4'h3, OPERAND=4'h5, PC=1.
  - After 6 cycles: PC=3, last OPCODE=4'h1.
- Jump: in EXEC with PC=5, LOAD_PC=1, LOAD_ADDR=12'h0F0 → next cycle PC=12'h0F0, PHASE=0. LOAD_PC=1 held during FETCH → PC is not reloaded.
- ROM_LAT=1, ROM[0]=8'hC2: from reset, cycle 1 FETCH, cycle 2 WAIT, cycle 3 EXEC with OPCODE=4'hC, OPERAND=4'h2, PC=1, VALID=1.
- Halt/resume with simultaneous events: EXEC with HALT_REQ=1 and LOAD_PC=1 (LOAD_ADDR=12'h100) → HALTED=1, PC unchanged. Apply LOAD_PC=1 during HALT → ignored. RESUME=1 → FETCH, fetch resumes at the unchanged PC.
- Wrap and ENABLE gating:
  - LOAD_PC to 12'hFFF, then fetch → PC=12'h000, WRAP=1.
  - ENABLE=0 for 4 cycles → PC, IR, PHASE and WRAP unchanged.
  - Next honoured LOAD_PC → WRAP=0.
- Reset mid-operation: RST=0 during WAIT with PC=12'h07A → next edge PC=0, state FETCH, VALID=0, WRAP=0, even though ENABLE=1 and RESUME=1.
